ps2_key_tracker: RTL and testbench

//  Converts PS/2 set-2 scancode bytes from the keyboard receiver into the 32-bit held-key mask.
//  The mask drives the per-key sine generators: bit i gates key i's oscillator.

---
 rtl/piano_kbd_pkg.sv | 35 +++
 rtl/scancode_to_key.sv | 23 ++
 rtl/ps2_key_tracker.sv | 127 ++++++++++++
 tb/tb_ps2_key_tracker.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_kbd_pkg.sv
// Shared definitions for the PS/2 piano keyboard front end: decoder states,
// special scancode bytes and the scancode-to-key map.
package piano_kbd_pkg;

  // Prefix-tracking decoder states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } kbd_state_t;

  // Special set-2 bytes
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ERR_00 = 8'h00;
  localparam logic [7:0] SC_ERR_FF = 8'hFF;
  localparam logic [7:0] SC_RESEND = 8'hFE;

  localparam int NUM_KEYS = 32;

  // Entry i is the make code of key i (key i drives mask bit i)
  localparam logic [7:0] KEYMAP [NUM_KEYS] = '{
    8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32,
    8'h33, 8'h31, 8'h3B, 8'h3A, 8'h41,
    8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C,
    8'h36, 8'h35, 8'h3D, 8'h3C, 8'h43, 8'h46, 8'h44, 8'h45,
    8'h4D,
    8'h54, 8'h5B
  };

endpackage

// File: rtl/scancode_to_key.sv
// Combinational lookup of a scancode in the key map: hit=1 and idx=key number
// when the code belongs to a piano key.
module scancode_to_key
  import piano_kbd_pkg::*;
(
  input  logic [7:0] code,
  output logic       hit,
  output logic [4:0] idx
);

  // Linear search of the table; codes are unique so at most one entry matches
  always_comb begin
    hit = 1'b0;
    idx = 5'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (code == KEYMAP[i]) begin
        hit = 1'b1;
        idx = 5'(i);
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Turns the PS/2 set-2 byte stream into a held-key mask for the sine bank.
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; there is no
// back-pressure, so every strobed byte is consumed in the cycle it appears and
// its effect is visible on the registered outputs after the next rising edge.
module ps2_key_tracker
  import piano_kbd_pkg::*;
#(
  parameter int MAX_KEYS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] keyPressed,
  output logic        key_evt,
  output logic [4:0]  key_evt_idx,
  output logic        key_evt_make,
  output logic        kbd_error
);

  localparam logic [5:0] CAP = 6'(MAX_KEYS);

  kbd_state_t  state, state_next;
  logic [31:0] mask_next;
  logic        evt_next, make_next, err_next;
  logic        do_make, do_break;
  logic        key_hit;
  logic [4:0]  key_idx;

  logic [5:0]  pc_l0 [32];
  logic [5:0]  pc_l1 [16];
  logic [5:0]  pc_l2 [8];
  logic [5:0]  pc_l3 [4];
  logic [5:0]  pc_l4 [2];
  logic [5:0]  pc_total;

  scancode_to_key u_map (
    .code (rx_data),
    .hit  (key_hit),
    .idx  (key_idx)
  );

  // Popcount of the registered mask as a balanced adder tree
  always_comb begin
    for (int i = 0; i < 32; i++) pc_l0[i] = 6'(keyPressed[i]);
    for (int i = 0; i < 16; i++) pc_l1[i] = pc_l0[2*i] + pc_l0[2*i+1];
    for (int i = 0; i < 8; i++)  pc_l2[i] = pc_l1[2*i] + pc_l1[2*i+1];
    for (int i = 0; i < 4; i++)  pc_l3[i] = pc_l2[2*i] + pc_l2[2*i+1];
    for (int i = 0; i < 2; i++)  pc_l4[i] = pc_l3[2*i] + pc_l3[2*i+1];
    pc_total = pc_l4[0] + pc_l4[1];
  end

  // Prefix decoder and mask update; nothing moves without rx_valid
  always_comb begin
    state_next = state;
    mask_next  = keyPressed;
    evt_next   = 1'b0;
    make_next  = 1'b0;
    err_next   = 1'b0;
    do_make    = 1'b0;
    do_break   = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == SC_BREAK) begin
            state_next = BRK;
          end else if (rx_data == SC_EXT) begin
            state_next = EXT;
          end else if (rx_data == SC_ACK || rx_data == SC_BAT_OK ||
                       rx_data == SC_ECHO) begin
            state_next = IDLE;
          end else if (rx_data == SC_ERR_00 || rx_data == SC_ERR_FF ||
                       rx_data == SC_RESEND) begin
            // Keyboard trouble: silence everything rather than risk stuck notes
            mask_next = '0;
            err_next  = 1'b1;
          end else begin
            do_make = 1'b1;
          end
        end
        BRK: begin
          do_break   = 1'b1;
          state_next = IDLE;
        end
        EXT: begin
          state_next = (rx_data == SC_BREAK) ? EXT_BRK : IDLE;
        end
        EXT_BRK: begin
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
    // Auto-repeat makes and releases of silent keys fall through with no event
    if (do_make && key_hit && !keyPressed[key_idx] && pc_total < CAP) begin
      mask_next[key_idx] = 1'b1;
      evt_next           = 1'b1;
      make_next          = 1'b1;
    end
    if (do_break && key_hit && keyPressed[key_idx]) begin
      mask_next[key_idx] = 1'b0;
      evt_next           = 1'b1;
    end
  end

  // Output and state registers; event index/direction hold until the next event
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      keyPressed   <= '0;
      key_evt      <= 1'b0;
      key_evt_idx  <= '0;
      key_evt_make <= 1'b0;
      kbd_error    <= 1'b0;
    end else begin
      state      <= state_next;
      keyPressed <= mask_next;
      key_evt    <= evt_next;
      kbd_error  <= err_next;
      if (evt_next) begin
        key_evt_idx  <= key_idx;
        key_evt_make <= make_next;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: two instances (no cap and MAX_KEYS=2) share one
// byte stream; a reference model per instance pushes expected events, and a
// monitor per instance pops and compares whenever the DUT signals an event.
module tb_ps2_key_tracker;

  logic        clk;
  logic        resetn;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic [31:0] kp_a, kp_b;
  logic        evt_a, evt_b, make_a, make_b, err_a, err_b;
  logic [4:0]  idx_a, idx_b;

  int checks = 0;
  int errors = 0;

  // Expected record: {err, make, idx[4:0], mask[31:0]}
  logic [38:0] exp_q_a[$];
  logic [38:0] exp_q_b[$];

  // Reference model state, one slot per instance
  logic [31:0] m_mask [2];
  bit          m_brk  [2];
  bit          m_ext  [2];
  int          m_cap  [2] = '{32, 2};

  // Piano key codes in key order
  logic [7:0] key_codes [32] = '{
    8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32, 8'h33, 8'h31,
    8'h3B, 8'h3A, 8'h41, 8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E,
    8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C, 8'h43, 8'h46, 8'h44, 8'h45, 8'h4D,
    8'h54, 8'h5B
  };

  ps2_key_tracker #(.MAX_KEYS(32)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .keyPressed(kp_a), .key_evt(evt_a), .key_evt_idx(idx_a),
    .key_evt_make(make_a), .kbd_error(err_a)
  );

  ps2_key_tracker #(.MAX_KEYS(2)) dut_cap (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .keyPressed(kp_b), .key_evt(evt_b), .key_evt_idx(idx_b),
    .key_evt_make(make_b), .kbd_error(err_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic int key_index(input logic [7:0] b);
    for (int i = 0; i < 32; i++) if (key_codes[i] == b) return i;
    return -1;
  endfunction

  task automatic push_exp(input int m, input logic [38:0] r);
    if (m == 0) exp_q_a.push_back(r);
    else        exp_q_b.push_back(r);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_mask[m] = '0;
      m_brk[m]  = 1'b0;
      m_ext[m]  = 1'b0;
    end
  endtask

  task automatic model_byte(input int m, input logic [7:0] b);
    int k;
    logic [31:0] mk;
    k  = key_index(b);
    mk = m_mask[m];
    if (m_ext[m] && m_brk[m]) begin
      m_ext[m] = 1'b0;
      m_brk[m] = 1'b0;
    end else if (m_ext[m]) begin
      if (b == 8'hF0) m_brk[m] = 1'b1;
      else            m_ext[m] = 1'b0;
    end else if (m_brk[m]) begin
      m_brk[m] = 1'b0;
      if (k >= 0 && mk[k]) begin
        mk[k] = 1'b0;
        push_exp(m, {1'b0, 1'b0, 5'(k), mk});
      end
    end else begin
      case (b)
        8'hF0: m_brk[m] = 1'b1;
        8'hE0: m_ext[m] = 1'b1;
        8'hFA, 8'hAA, 8'hEE: ;
        8'h00, 8'hFF, 8'hFE: begin
          mk = '0;
          push_exp(m, {1'b1, 1'b0, 5'd0, mk});
        end
        default: begin
          if (k >= 0 && !mk[k] && $countones(mk) < m_cap[m]) begin
            mk[k] = 1'b1;
            push_exp(m, {1'b0, 1'b1, 5'(k), mk});
          end
        end
      endcase
    end
    m_mask[m] = mk;
  endtask

  // ---------------- monitors / scoreboard ----------------
  task automatic mon_check(input string name, input logic [38:0] e, input logic evt,
                           input logic err, input logic [4:0] idx, input logic make,
                           input logic [31:0] kp);
    bit ok;
    checks++;
    ok = (err == e[38]) && (evt == !e[38]) && (kp == e[31:0]) &&
         (e[38] || (idx == e[36:32] && make == e[37]));
    if (!ok) begin
      errors++;
      $display("FAIL %s event: got evt=%0b err=%0b idx=%0d make=%0b mask=%h, want err=%0b idx=%0d make=%0b mask=%h",
               name, evt, err, idx, make, kp, e[38], e[36:32], e[37], e[31:0]);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && (evt_a || err_a)) begin
      if (exp_q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut_a unexpected event: evt=%0b err=%0b idx=%0d make=%0b mask=%h, want none",
                 evt_a, err_a, idx_a, make_a, kp_a);
      end else begin
        mon_check("dut_a", exp_q_a.pop_front(), evt_a, err_a, idx_a, make_a, kp_a);
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && (evt_b || err_b)) begin
      if (exp_q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut_b unexpected event: evt=%0b err=%0b idx=%0d make=%0b mask=%h, want none",
                 evt_b, err_b, idx_b, make_b, kp_b);
      end else begin
        mon_check("dut_b", exp_q_b.pop_front(), evt_b, err_b, idx_b, make_b, kp_b);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(0, b);
    model_byte(1, b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_models(input string name);
    idle(2);
    check_val({name, " mask_a"}, kp_a, m_mask[0]);
    check_val({name, " mask_b"}, kp_b, m_mask[1]);
    check_val({name, " pending_a"}, 32'(exp_q_a.size()), 32'd0);
    check_val({name, " pending_b"}, 32'(exp_q_b.size()), 32'd0);
  endtask

  // One reset cycle; optionally strobe a byte that must be ignored
  task automatic do_reset(input bit with_byte, input logic [7:0] b);
    idle(1);
    resetn = 1'b0;
    if (with_byte) begin
      rx_data  = b;
      rx_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    resetn   = 1'b1;
    model_reset();
    check_val("reset mask_a", kp_a, 32'd0);
    check_val("reset mask_b", kp_b, 32'd0);
    check_val("reset pulses", {28'd0, evt_a, err_a, evt_b, err_b}, 32'd0);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] specials [3] = '{8'hFA, 8'hAA, 8'hEE};
    logic [7:0] errs     [3] = '{8'h00, 8'hFF, 8'hFE};
    r = $urandom_range(0, 99);
    if (r < 55) return key_codes[$urandom_range(0, 31)];
    if (r < 72) return 8'hF0;
    if (r < 79) return 8'hE0;
    if (r < 84) return specials[$urandom_range(0, 2)];
    if (r < 86) return errs[$urandom_range(0, 2)];
    return 8'($urandom_range(0, 255));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    resetn   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("por mask_a", kp_a, 32'd0);
    check_val("por mask_b", kp_b, 32'd0);
    check_val("por outs_a", {24'd0, evt_a, idx_a, make_a, err_a}, 32'd0);
    check_val("por outs_b", {24'd0, evt_b, idx_b, make_b, err_b}, 32'd0);
    resetn = 1'b1;

    // make then break of key 0
    send(8'h1A);
    idle(2);
    check_val("make 1A", kp_a, 32'h1);
    send(8'hF0); send(8'h1A);
    check_models("break 1A");
    check_val("break 1A", kp_a, 32'h0);

    // auto-repeat ignored
    send(8'h15); send(8'h15); send(8'h15);
    idle(2);
    check_val("repeat 15", kp_a, 32'h0000_2000);
    send(8'hF0); send(8'h15);
    check_models("repeat release");

    // extended make/break ignored
    send(8'hE0); send(8'h1A);
    send(8'hE0); send(8'hF0); send(8'h1A);
    check_models("extended");
    check_val("extended mask", kp_a, 32'h0);

    // polyphony cap on the MAX_KEYS=2 instance
    send(8'h1A); send(8'h1B); send(8'h22);
    check_models("cap fill");
    check_val("cap mask_b", kp_b, 32'h3);
    check_val("nocap mask_a", kp_a, 32'h7);
    send(8'hF0); send(8'h1A); send(8'h22);
    check_models("cap reuse");
    check_val("cap reuse mask_b", kp_b, 32'h6);

    // error byte silences everything
    do_reset(1'b0, 8'h00);
    send(8'h1A); send(8'h1B); send(8'h22); send(8'h23); send(8'h21);
    idle(2);
    check_val("five held", kp_a, 32'h1F);
    send(8'hFF);
    check_models("error FF");
    check_val("error mask_a", kp_a, 32'h0);

    // reset discards a pending break prefix; strobe during reset ignored
    send(8'hF0);
    do_reset(1'b1, 8'h1B);
    send(8'h1A);
    check_models("prefix discard");
    check_val("prefix discard mask", kp_a, 32'h1);

    // unmapped codes and back-to-back strobes
    do_reset(1'b0, 8'h00);
    send(8'h1C); send(8'hF0); send(8'h1C);
    check_models("unmapped");
    send(8'h1A); send(8'h1B); send(8'hF0); send(8'h1A);
    check_models("back to back");
    check_val("back to back mask", kp_a, 32'h2);

    // randomized stream with random gaps
    for (int n = 0; n < 400; n++) begin
      send(rand_byte());
      idle($urandom_range(0, 2));
      if (n % 50 == 49) check_models("random");
    end
    check_models("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
